// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: combinational sum/cout plus a one-cycle
// registered copy tagged with valid and a signed-overflow flag.

module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (b_i & c_i) | (c_i & a_i);
endmodule

module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             cout,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             out_valid
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } res_t;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] s;
   logic             ovf;
   res_t             res_d, res_q;
   logic             vld_d, vld_q;

   assign carry[0] = cin;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      full_adder_cell u_cell (
         .a_i (a[g]),
         .b_i (b[g]),
         .c_i (carry[g]),
         .s_o (s[g]),
         .c_o (carry[g+1])
      );
   end

   assign sum  = s;
   assign cout = carry[WIDTH];
   // Carry into vs. out of the sign bit; for WIDTH=1 the sign bit's carry-in is cin.
   assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

   always_comb begin
      res_d = res_q;
      vld_d = in_valid;
      if (in_valid) begin
         res_d.sum  = s;
         res_d.cout = carry[WIDTH];
         res_d.ovf  = ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         vld_q <= 1'b0;
      end else begin
         res_q <= res_d;
         vld_q <= vld_d;
      end
   end

   assign sum_q     = res_q.sum;
   assign cout_q    = res_q.cout;
   assign ovf_q     = res_q.ovf;
   assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1/4/8 against an arithmetic reference model.

module tb_full_adder;

   logic       clk, rst_n, in_valid;
   logic       a1, b1, c1, s1, co1, sq1, cq1, oq1, v1;
   logic [3:0] a4, b4, s4, sq4;
   logic       c4, co4, cq4, oq4, v4;
   logic [7:0] a8, b8, s8, sq8;
   logic       c8, co8, cq8, oq8, v8;

   full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(c1),
      .cout(co1), .sum(s1), .sum_q(sq1), .cout_q(cq1), .ovf_q(oq1), .out_valid(v1));
   full_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .cin(c4),
      .cout(co4), .sum(s4), .sum_q(sq4), .cout_q(cq4), .ovf_q(oq4), .out_valid(v4));
   full_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(c8),
      .cout(co8), .sum(s8), .sum_q(sq8), .cout_q(cq8), .ovf_q(oq8), .out_valid(v8));

   initial clk = 1'b0;
   always #20 clk = ~clk;

   logic [7:0] o_sum[3], r_sum[3];
   logic       o_cout[3], r_cout[3], r_ovf[3], r_vld[3];
   assign o_sum[0] = {7'd0, s1};  assign o_sum[1] = {4'd0, s4};  assign o_sum[2] = s8;
   assign r_sum[0] = {7'd0, sq1}; assign r_sum[1] = {4'd0, sq4}; assign r_sum[2] = sq8;
   assign o_cout = '{co1, co4, co8};
   assign r_cout = '{cq1, cq4, cq8};
   assign r_ovf  = '{oq1, oq4, oq8};
   assign r_vld  = '{v1, v4, v8};

   int W[3] = '{1, 4, 8};
   int ta[3], tb_[3], tc[3];
   int ps[3], pc[3], po[3];
   int es[3], ec[3], eo[3], ev[3];
   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from the signed sum leaving range.
   task automatic model(input int w, input int a, input int b, input int c,
                        output int s, output int co, output int ov);
      int tot, sa, sb, rs;
      tot = a + b + c;
      s   = tot % (1 << w);
      co  = tot >> w;
      sa  = (a >= (1 << (w-1))) ? a - (1 << w) : a;
      sb  = (b >= (1 << (w-1))) ? b - (1 << w) : b;
      rs  = sa + sb + c;
      ov  = (rs > (1 << (w-1)) - 1 || rs < -(1 << (w-1))) ? 1 : 0;
   endtask

   task automatic comb_chk(input logic v);
      int s, co, ov;
      a1 = ta[0][0];   b1 = tb_[0][0];   c1 = tc[0][0];
      a4 = ta[1][3:0]; b4 = tb_[1][3:0]; c4 = tc[1][0];
      a8 = ta[2][7:0]; b8 = tb_[2][7:0]; c8 = tc[2][0];
      in_valid = v;
      #1;
      for (int i = 0; i < 3; i++) begin
         model(W[i], ta[i], tb_[i], tc[i], s, co, ov);
         chk($sformatf("comb_sum_w%0d", W[i]), 32'(o_sum[i]), s);
         chk($sformatf("comb_cout_w%0d", W[i]), 32'(o_cout[i]), co);
         ps[i] = s; pc[i] = co; po[i] = ov;
      end
   endtask

   task automatic reg_chk(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_sumq_w%0d", tag, W[i]), 32'(r_sum[i]), es[i]);
         chk($sformatf("%s_coutq_w%0d", tag, W[i]), 32'(r_cout[i]), ec[i]);
         chk($sformatf("%s_ovfq_w%0d", tag, W[i]), 32'(r_ovf[i]), eo[i]);
         chk($sformatf("%s_vld_w%0d", tag, W[i]), 32'(r_vld[i]), ev[i]);
      end
   endtask

   // Called just after a negedge; returns at the next negedge.
   task automatic step(input string tag, input logic v);
      comb_chk(v);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (v && rst_n) begin
            es[i] = ps[i]; ec[i] = pc[i]; eo[i] = po[i];
         end
         ev[i] = (v && rst_n) ? 1 : 0;
      end
      reg_chk(tag);
      @(negedge clk);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 3; i++) begin
         ta[i]  = int'($urandom_range((1 << W[i]) - 1));
         tb_[i] = int'($urandom_range((1 << W[i]) - 1));
         tc[i]  = int'($urandom_range(1));
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 3; i++) begin
         es[i] = 0; ec[i] = 0; eo[i] = 0; ev[i] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin ta[i] = 0; tb_[i] = 0; tc[i] = 0; end
      clear_exp();
      #3;
      reg_chk("reset");

      // Exhaustive and random 1-bit combos, combinational only, while in reset
      for (int k = 0; k < 8; k++) begin
         ta[0] = (k >> 2) & 1; tb_[0] = (k >> 1) & 1; tc[0] = k & 1;
         comb_chk(1'b1);
      end
      for (int k = 0; k < 8; k++) begin
         rand_ops();
         comb_chk(1'b1);
      end
      reg_chk("held_reset");

      @(negedge clk);
      rst_n = 1'b1;

      // Boundaries: all-zeros, all-ones + all-ones + 1
      for (int i = 0; i < 3; i++) begin ta[i] = 0; tb_[i] = 0; tc[i] = 0; end
      step("zeros", 1'b1);
      for (int i = 0; i < 3; i++) begin
         ta[i] = (1 << W[i]) - 1; tb_[i] = (1 << W[i]) - 1; tc[i] = 1;
      end
      step("ones", 1'b1);

      // FF+00+1 wraps to 0 with carry; 7F+01 is a signed overflow
      ta[2] = 'hFF; tb_[2] = 'h00; tc[2] = 1;
      step("wrap", 1'b1);
      chk("wrap_sumq_exact", 32'(sq8), 0);
      chk("wrap_coutq_exact", 32'(cq8), 1);
      ta[2] = 'h7F; tb_[2] = 'h01; tc[2] = 0;
      step("ovf", 1'b1);
      chk("ovf_sumq_exact", 32'(sq8), 'h80);
      chk("ovf_ovfq_exact", 32'(oq8), 1);

      // Latency and hold: 3+4+1 -> 8, then in_valid low keeps 8
      ta[1] = 3; tb_[1] = 4; tc[1] = 1;
      step("lat", 1'b1);
      chk("lat_sumq_exact", 32'(sq4), 8);
      rand_ops();
      step("hold", 1'b0);
      chk("hold_sumq_exact", 32'(sq4), 8);

      // Random traffic with random valid
      for (int k = 0; k < 40; k++) begin
         rand_ops();
         step("rand", 1'($urandom_range(1)));
      end

      // Asynchronous reset mid-operation
      rand_ops();
      step("pre_rst", 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      clear_exp();
      reg_chk("async_rst");
      rand_ops();
      comb_chk(1'b1);
      @(negedge clk);
      rand_ops();
      step("in_rst", 1'b1);
      rst_n = 1'b1;
      rand_ops();
      step("post_rst", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end

endmodule
